// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply controller driving a shared modular multiplier.
// Optional feature: define MOD_EXP_MODCHECK_EN to reject moduli below 2 (err flag).
module mod_exp_ctrl #(
    parameter int W  = 3,
    parameter int EW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  base,
    input  logic [EW-1:0] expo,
    input  logic [W-1:0]  modulus,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result,
    output logic          err,
    output logic          mm_start,
    output logic [W-1:0]  mm_a,
    output logic [W-1:0]  mm_b,
    output logic [W-1:0]  mm_m,
    input  logic          mm_done,
    input  logic [W-1:0]  mm_result
);

    localparam int IW = (EW > 1) ? $clog2(EW) : 1;
    localparam logic [W-1:0]  ONE_W  = W'(1'b1);
    localparam logic [IW-1:0] ONE_I  = IW'(1'b1);
    localparam logic [IW-1:0] I_TOP  = IW'(EW - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RED_REQ  = 3'd1,
        RED_WAIT = 3'd2,
        SQR_REQ  = 3'd3,
        SQR_WAIT = 3'd4,
        MUL_REQ  = 3'd5,
        MUL_WAIT = 3'd6,
        FIN      = 3'd7
    } state_t;

    state_t         state_r;
    logic [W-1:0]   b_r;
    logic [EW-1:0]  e_r;
    logic [W-1:0]   r_r;
    logic [IW-1:0]  i_r;

    logic           last_step_s;
    logic           bit_set_s;
    logic           mod_bad_s;

    // Step-end and exponent-bit decisions for the current iteration.
    always_comb begin
        last_step_s = (i_r == {IW{1'b0}});
        if (32'(i_r) < EW) begin
            bit_set_s = e_r[i_r];
        end else begin
            bit_set_s = 1'b0;
        end
    end

`ifdef MOD_EXP_MODCHECK_EN
    // A modulus of 0 or 1 has no meaningful residue system.
    always_comb begin
        if (modulus < W'(2'd2)) begin
            mod_bad_s = 1'b1;
        end else begin
            mod_bad_s = 1'b0;
        end
    end
`else
    assign mod_bad_s = 1'b0;
`endif

    // Control FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            b_r      <= {W{1'b0}};
            e_r      <= {EW{1'b0}};
            r_r      <= {W{1'b0}};
            i_r      <= {IW{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            result   <= {W{1'b0}};
            mm_start <= 1'b0;
            mm_a     <= {W{1'b0}};
            mm_b     <= {W{1'b0}};
            mm_m     <= {W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        b_r  <= base;
                        e_r  <= expo;
                        r_r  <= ONE_W;
                        i_r  <= I_TOP;
                        busy <= 1'b1;
                        if (mod_bad_s) begin
                            err     <= 1'b1;
                            result  <= {W{1'b0}};
                            done    <= 1'b1;
                            state_r <= FIN;
                        end else begin
                            err      <= 1'b0;
                            mm_start <= 1'b1;
                            mm_a     <= base;
                            mm_b     <= ONE_W;
                            mm_m     <= modulus;
                            state_r  <= RED_REQ;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RED_REQ: begin
                    mm_start <= 1'b0;
                    state_r  <= RED_WAIT;
                end
                RED_WAIT: begin
                    if (mm_done) begin
                        // Reduced base replaces the raw operand for all later multiplies.
                        b_r      <= mm_result;
                        mm_start <= 1'b1;
                        mm_a     <= r_r;
                        mm_b     <= r_r;
                        state_r  <= SQR_REQ;
                    end else begin
                        state_r <= RED_WAIT;
                    end
                end
                SQR_REQ: begin
                    mm_start <= 1'b0;
                    state_r  <= SQR_WAIT;
                end
                SQR_WAIT: begin
                    if (mm_done) begin
                        r_r <= mm_result;
                        if (bit_set_s) begin
                            mm_start <= 1'b1;
                            mm_a     <= mm_result;
                            mm_b     <= b_r;
                            state_r  <= MUL_REQ;
                        end else if (last_step_s) begin
                            result  <= mm_result;
                            done    <= 1'b1;
                            state_r <= FIN;
                        end else begin
                            i_r      <= i_r - ONE_I;
                            mm_start <= 1'b1;
                            mm_a     <= mm_result;
                            mm_b     <= mm_result;
                            state_r  <= SQR_REQ;
                        end
                    end else begin
                        state_r <= SQR_WAIT;
                    end
                end
                MUL_REQ: begin
                    mm_start <= 1'b0;
                    state_r  <= MUL_WAIT;
                end
                MUL_WAIT: begin
                    if (mm_done) begin
                        r_r <= mm_result;
                        if (last_step_s) begin
                            result  <= mm_result;
                            done    <= 1'b1;
                            state_r <= FIN;
                        end else begin
                            i_r      <= i_r - ONE_I;
                            mm_start <= 1'b1;
                            mm_a     <= mm_result;
                            mm_b     <= mm_result;
                            state_r  <= SQR_REQ;
                        end
                    end else begin
                        state_r <= MUL_WAIT;
                    end
                end
                FIN: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    mm_start <= 1'b0;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule
